// File: rtl/gate_vec_pipe.sv
// Registered bitwise gate unit: eight gate functions on WIDTH-bit operands,
// returned through a valid/ready output stage with a 2-entry skid buffer.
// Optional result parity output s_par is enabled by defining GATE_VEC_PIPE_PARITY_EN.
module gate_vec_pipe #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] e1,
    input  logic [WIDTH-1:0] e2,
    input  logic [OPW-1:0]   op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] s,
    output logic             s_valid,
    input  logic             s_ready
`ifdef GATE_VEC_PIPE_PARITY_EN
    ,
    output logic             s_par
`endif
);

    generate
        if (OPW != 3) begin : g_opw_check
            $error("gate_vec_pipe: OPW must be 3");
        end
    endgenerate

    logic [WIDTH-1:0] result;
    logic             accept;
    logic             main_free;

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
`ifdef GATE_VEC_PIPE_PARITY_EN
    logic             main_par_q, main_par_d;
    logic             skid_par_q, skid_par_d;
`endif

    always_comb begin
        result = e1;
        case (op)
            3'd0:    result = e1;
            3'd1:    result = ~e1;
            3'd2:    result = e1 & e2;
            3'd3:    result = e1 | e2;
            3'd4:    result = e1 ^ e2;
            3'd5:    result = ~(e1 ^ e2);
            3'd6:    result = ~(e1 & e2);
            3'd7:    result = ~(e1 | e2);
            default: result = e1;
        endcase
    end

    // A full skid always drains into main first, so accepts only ever land
    // in skid when main is stalled.
    assign accept    = in_valid & ~skid_valid_q;
    assign main_free = ~main_valid_q | s_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
`ifdef GATE_VEC_PIPE_PARITY_EN
        main_par_d   = main_par_q;
        skid_par_d   = skid_par_q;
`endif
        if (main_free) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
`ifdef GATE_VEC_PIPE_PARITY_EN
                main_par_d   = skid_par_q;
`endif
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = result;
`ifdef GATE_VEC_PIPE_PARITY_EN
                main_par_d   = ^result;
`endif
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = result;
`ifdef GATE_VEC_PIPE_PARITY_EN
            skid_par_d   = ^result;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
`ifdef GATE_VEC_PIPE_PARITY_EN
            main_par_q   <= 1'b0;
            skid_par_q   <= 1'b0;
`endif
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
`ifdef GATE_VEC_PIPE_PARITY_EN
            main_par_q   <= main_par_d;
            skid_par_q   <= skid_par_d;
`endif
        end
    end

    assign in_ready = ~skid_valid_q;
    assign s        = main_data_q;
    assign s_valid  = main_valid_q;
`ifdef GATE_VEC_PIPE_PARITY_EN
    assign s_par    = main_par_q;
`endif

endmodule

// File: tb/tb_gate_vec_pipe.sv
// Self-checking bench for gate_vec_pipe: directed steps plus a scoreboard
// monitor that checks data, order, occupancy and hold on every cycle.
module tb_gate_vec_pipe;

    localparam int W = 8;

    typedef struct packed {
        logic         par;
        logic [W-1:0] data;
    } entry_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] e1;
    logic [W-1:0] e2;
    logic [2:0]   op;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] s;
    logic         s_valid;
    logic         s_ready;
`ifdef GATE_VEC_PIPE_PARITY_EN
    logic         s_par;
`endif

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;

    entry_t       sb[$];
    logic [W-1:0] out_log[$];
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_s = '0;

    gate_vec_pipe #(.WIDTH(W), .OPW(3)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .e1       (e1),
        .e2       (e2),
        .op       (op),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .s        (s),
        .s_valid  (s_valid),
        .s_ready  (s_ready)
`ifdef GATE_VEC_PIPE_PARITY_EN
        ,
        .s_par    (s_par)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] gateModel(input logic [2:0] f, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        case (f)
            3'd0:    return a;
            3'd1:    return ~a;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reportTimeout(input string tag);
        checks++;
        errors++;
        $error("[TB] FAIL %s timeout observed=busy expected=done", tag);
    endtask

    // Called just after each rising edge to apply the current s_ready policy.
    task automatic stepReady();
        if (ready_mode == 1)      s_ready = ~s_ready;
        else if (ready_mode == 2) s_ready = 1'($urandom_range(0, 1));
    endtask

    // Offers one transaction and holds it until the DUT takes it.
    task automatic applyStimulus(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        int  n = 0;
        logic ok;
        op = f; e1 = a; e2 = b; in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            stepReady();
            n++;
        end while (!ok && n < 200);
        in_valid = 1'b0;
        if (!ok) reportTimeout("accept");
    endtask

    task automatic drain();
        int n = 0;
        ready_mode = 0;
        s_ready = 1'b1;
        while ((sb.size() != 0 || s_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) reportTimeout("drain");
    endtask

    // Scoreboard monitor: sampled mid-cycle, it sees the handshakes that the
    // next rising edge will act on.
    always @(negedge clk) begin
        entry_t exp_e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            checkOutput("s_valid_occ", 64'(s_valid), 64'(sb.size() > 0));
            checkOutput("in_ready_occ", 64'(in_ready), 64'(sb.size() < 2));
            if (prev_stall) checkOutput("hold", 64'(s), 64'(prev_s));
            if (in_valid) checkOutput("op_known", 64'($isunknown(op)), 64'(0));
            if (s_valid && s_ready) begin
                if (sb.size() == 0) begin
                    reportTimeout("sb_unexpected_output");
                end else begin
                    exp_e = sb.pop_front();
                    checkOutput("sb_data", 64'(s), 64'(exp_e.data));
`ifdef GATE_VEC_PIPE_PARITY_EN
                    checkOutput("sb_par", 64'(s_par), 64'(exp_e.par));
`endif
                end
                out_log.push_back(s);
            end
            if (in_valid && in_ready) begin
                exp_e.data = gateModel(op, e1, e2);
                exp_e.par  = ^exp_e.data;
                sb.push_back(exp_e);
            end
            prev_stall = s_valid && !s_ready;
            prev_s     = s;
        end
    end

    initial begin
        logic [W-1:0] tbl[8];
        logic [W-1:0] held;
        tbl = '{8'hA5, 8'h5A, 8'h24, 8'hBD, 8'h99, 8'h66, 8'hDB, 8'h42};

        rst_n = 1'b0; in_valid = 1'b0; s_ready = 1'b1;
        e1 = '0; e2 = '0; op = '0;
        #12;
        checkOutput("rst_s", 64'(s), 64'(0));
        checkOutput("rst_s_valid", 64'(s_valid), 64'(0));
        checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
`ifdef GATE_VEC_PIPE_PARITY_EN
        checkOutput("rst_s_par", 64'(s_par), 64'(0));
`endif
        #11 rst_n = 1'b1;

        $display("[TB] all opcodes, continuous ready");
        for (int i = 0; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i < 8) begin
                op = 3'(i); e1 = 8'hA5; e2 = 8'h3C; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i > 0) begin
                checkOutput($sformatf("op%0d_s", i - 1), 64'(s), 64'(tbl[i-1]));
                checkOutput($sformatf("op%0d_valid", i - 1), 64'(s_valid), 64'(1));
`ifdef GATE_VEC_PIPE_PARITY_EN
                checkOutput($sformatf("op%0d_par", i - 1), 64'(s_par), 64'(0));
`endif
            end
        end
        drain();

        $display("[TB] backpressure");
        out_log.delete();
        @(posedge clk);
        #1;
        s_ready = 1'b0;
        applyStimulus(3'd4, 8'h01, 8'h00);
        applyStimulus(3'd4, 8'h02, 8'h00);
        op = 3'd4; e1 = 8'h03; e2 = 8'h00; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 64'(in_ready), 64'(0));
            checkOutput("bp_s_stall", 64'(s), 64'(8'h01));
            @(posedge clk);
            #1;
        end
        s_ready = 1'b1;
        begin
            int  n = 0;
            logic ok;
            do begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                n++;
            end while (!ok && n < 50);
            in_valid = 1'b0;
            if (!ok) reportTimeout("bp_third_accept");
        end
        drain();
        checkOutput("bp_count", 64'(out_log.size()), 64'(3));
        for (int k = 0; k < 3; k++)
            if (out_log.size() > k) checkOutput("bp_order", 64'(out_log[k]), 64'(k + 1));

        $display("[TB] alternating ready");
        out_log.delete();
        ready_mode = 1;
        for (int i = 0; i < 16; i++) applyStimulus(3'd3, 8'(8'h20 + i), 8'h00);
        drain();
        checkOutput("alt_count", 64'(out_log.size()), 64'(16));
        for (int k = 0; k < 16; k++)
            if (out_log.size() > k) checkOutput("alt_order", 64'(out_log[k]), 64'(8'h20 + k));

        $display("[TB] async reset with two held");
        s_ready = 1'b0;
        applyStimulus(3'd0, 8'h11, 8'h00);
        applyStimulus(3'd0, 8'h22, 8'h00);
        @(negedge clk);
        checkOutput("full_before_rst", 64'(in_ready), 64'(0));
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checkOutput("mid_rst_s", 64'(s), 64'(0));
        checkOutput("mid_rst_s_valid", 64'(s_valid), 64'(0));
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'(1));
`ifdef GATE_VEC_PIPE_PARITY_EN
        checkOutput("mid_rst_s_par", 64'(s_par), 64'(0));
`endif
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        s_ready = 1'b1;
        out_log.delete();
        @(posedge clk);
        #1;
        applyStimulus(3'd2, 8'hF0, 8'h3C);
        drain();
        checkOutput("post_rst_count", 64'(out_log.size()), 64'(1));
        if (out_log.size() > 0) checkOutput("post_rst_data", 64'(out_log[0]), 64'(8'h30));

        $display("[TB] random traffic");
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                stepReady();
            end
            applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
        drain();

        $display("[TB] idle with toggling inputs");
        held = s;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            e1 = 8'($urandom); e2 = 8'($urandom); op = 3'($urandom_range(0, 7));
            s_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOutput("idle_s_valid", 64'(s_valid), 64'(0));
            checkOutput("idle_s", 64'(s), 64'(held));
        end
        checkOutput("sb_empty", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
